// File: rtl/toggle_pulse_gen_if.sv
// Button-side signal bundle for toggle_pulse_gen.
// The master drives the raw button level; the slave (the pulse generator)
// returns the toggle pulse and the debounced level.
interface toggle_pulse_gen_if;
    logic btn_in;
    logic T;
    logic btn_level;

    modport master (
        output btn_in,
        input  T,
        input  btn_level
    );

    modport slave (
        input  btn_in,
        output T,
        output btn_level
    );
endinterface

// File: rtl/toggle_pulse_gen.sv
// Debounced push-button to one-clock toggle pulse, with optional auto-repeat.
// Feeds TFF_Sync.T directly; shares clk and reset with it.
//
//   state        | meaning
//   -------------+-------------------------------------------------------
//   IDLE         | button released, waiting for a high sample
//   PRESS_WAIT   | counting consecutive high samples before accepting
//   PRESSED      | press accepted, btn_level=1, optional auto-repeat
//   RELEASE_WAIT | counting consecutive low samples before accepting
module toggle_pulse_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic               clk,
    input  logic               reset,
    toggle_pulse_gen_if.slave  bus
);

    localparam int MAX_COUNT = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);

    // The FSM registers act as the final synchroniser stage, so the explicit
    // chain is one flop shorter. This keeps the first pulse exactly
    // SYNC_STAGES+DEBOUNCE_CYCLES edges after the first high sample.
    localparam int CHAIN = SYNC_STAGES - 1;

    // A period of 1 would give back-to-back pulses, which TFF_Sync would see
    // as a held T; the shortest usable repeat period is therefore 2.
    localparam bit REPEAT_ON  = (REPEAT_CYCLES > 0);
    localparam int REP_PERIOD = (REPEAT_CYCLES == 1) ? 2 : REPEAT_CYCLES;
    localparam int REP_LAST_I = REPEAT_ON ? (REP_PERIOD - 1) : 0;

    localparam logic [CNT_W-1:0] DEB_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_LAST_I);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [CHAIN-1:0] sync_q;
    logic             btn_sync;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             t_q, t_d;
    logic             lvl_q, lvl_d;

    assign btn_sync = sync_q[CHAIN-1];

    // Shift the raw button level through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= CHAIN'({sync_q, bus.btn_in});
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            deb_q   <= '0;
            rep_q   <= '0;
            t_q     <= 1'b0;
            lvl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            rep_q   <= rep_d;
            t_q     <= t_d;
            lvl_q   <= lvl_d;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        rep_d   = rep_q;
        t_d     = 1'b0;
        lvl_d   = lvl_q;

        case (state_q)
            IDLE: begin
                lvl_d = 1'b0;
                if (btn_sync) begin
                    state_d = PRESS_WAIT;
                    deb_d   = CNT_ONE;
                end
            end

            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                    deb_d   = '0;
                end else if (deb_q == DEB_DONE) begin
                    state_d = PRESSED;
                    t_d     = 1'b1;
                    lvl_d   = 1'b1;
                    rep_d   = '0;
                end else begin
                    deb_d = deb_q + CNT_ONE;
                end
            end

            PRESSED: begin
                if (!btn_sync) begin
                    state_d = RELEASE_WAIT;
                    deb_d   = CNT_ONE;
                end else if (REPEAT_ON) begin
                    if (rep_q == REP_LAST) begin
                        t_d   = 1'b1;
                        rep_d = '0;
                    end else begin
                        rep_d = rep_q + CNT_ONE;
                    end
                end
            end

            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_d = PRESSED;
                    rep_d   = '0;
                end else if (deb_q == DEB_DONE) begin
                    state_d = IDLE;
                    lvl_d   = 1'b0;
                    deb_d   = '0;
                end else begin
                    deb_d = deb_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                deb_d   = '0;
                rep_d   = '0;
                lvl_d   = 1'b0;
            end
        endcase
    end

    assign bus.T         = t_q;
    assign bus.btn_level = lvl_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed bench for toggle_pulse_gen.
// u0: defaults (2/4/0), u1: auto-repeat period 5, u2: single-sample debounce.
// A behavioural TFF_Sync model follows u0.T.
module tb_toggle_pulse_gen;

    logic clk = 1'b0;
    logic reset;
    logic btn;
    logic q;

    int checks   = 0;
    int failures = 0;

    always #2 clk = ~clk;

    toggle_pulse_gen_if i0 ();
    toggle_pulse_gen_if i1 ();
    toggle_pulse_gen_if i2 ();

    assign i0.btn_in = btn;
    assign i1.btn_in = btn;
    assign i2.btn_in = btn;

    toggle_pulse_gen u0 (.clk(clk), .reset(reset), .bus(i0.slave));

    toggle_pulse_gen #(.REPEAT_CYCLES(5)) u1 (.clk(clk), .reset(reset), .bus(i1.slave));

    toggle_pulse_gen #(.DEBOUNCE_CYCLES(1)) u2 (.clk(clk), .reset(reset), .bus(i2.slave));

    // TFF_Sync reference: Q toggles on every T pulse, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) q <= 1'b0;
        else if (i0.T) q <= ~q;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        btn   = 1'b0;
        tick(2);
        chk("rst_T0",   i0.T, 1'b0);
        chk("rst_lvl0", i0.btn_level, 1'b0);
        chk("rst_q",    q, 1'b0);

        // 1: button high during reset -> nothing; after release, one pulse at edge 6.
        btn = 1'b1;
        for (int n = 1; n <= 2; n++) begin
            tick(1);
            chk($sformatf("t1_rst_T0_e%0d", n), i0.T, 1'b0);
            chk($sformatf("t1_rst_lvl0_e%0d", n), i0.btn_level, 1'b0);
            chk($sformatf("t1_rst_T2_e%0d", n), i2.T, 1'b0);
        end
        reset = 1'b0;

        // 1/2/5: held 31 clocks. u0 single pulse at 6; u1 pulses 6,11,..,31;
        // u2 (debounce 1) single pulse at 3.
        for (int n = 1; n <= 31; n++) begin
            tick(1);
            chk($sformatf("t2_T0_e%0d", n), i0.T, (n == 6));
            chk($sformatf("t2_lvl0_e%0d", n), i0.btn_level, (n >= 6));
            chk($sformatf("t5_T1_e%0d", n), i1.T,
                (n == 6 || n == 11 || n == 16 || n == 21 || n == 26 || n == 31));
            chk($sformatf("d1_T2_e%0d", n), i2.T, (n == 3));
            chk($sformatf("d1_lvl2_e%0d", n), i2.btn_level, (n >= 3));
        end
        chk("t6_q_press1", q, 1'b1);

        // Release: level falls 6 edges after the fall (3 for debounce 1), no pulses.
        btn = 1'b0;
        for (int m = 1; m <= 8; m++) begin
            tick(1);
            chk($sformatf("rel_T0_e%0d", m), i0.T, 1'b0);
            chk($sformatf("rel_T1_e%0d", m), i1.T, 1'b0);
            chk($sformatf("rel_lvl0_e%0d", m), i0.btn_level, (m < 6));
            chk($sformatf("rel_lvl1_e%0d", m), i1.btn_level, (m < 6));
            chk($sformatf("rel_lvl2_e%0d", m), i2.btn_level, (m < 3));
        end

        // 3: 3-clock glitch is rejected.
        btn = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick(1);
            if (n == 3) btn = 1'b0;
            chk($sformatf("t3_T0_e%0d", n), i0.T, 1'b0);
            chk($sformatf("t3_lvl0_e%0d", n), i0.btn_level, 1'b0);
            chk($sformatf("t3_T1_e%0d", n), i1.T, 1'b0);
        end
        chk("t3_q", q, 1'b1);

        // 4: samples 1,0,1,0 then held -> pulse at edge 10 only.
        btn = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick(1);
            btn = (n == 1 || n == 3) ? 1'b0 : 1'b1;
            chk($sformatf("t4_T0_e%0d", n), i0.T, (n == 10));
            chk($sformatf("t4_lvl0_e%0d", n), i0.btn_level, (n >= 10));
        end
        chk("t6_q_press2", q, 1'b0);

        // 4: 2-clock release glitch -> no pulse, level stays high.
        btn = 1'b0;
        for (int r = 1; r <= 8; r++) begin
            tick(1);
            if (r == 2) btn = 1'b1;
            chk($sformatf("t4g_T0_e%0d", r), i0.T, 1'b0);
            chk($sformatf("t4g_lvl0_e%0d", r), i0.btn_level, 1'b1);
        end
        btn = 1'b0;
        tick(8);
        chk("t4_lvl0_released", i0.btn_level, 1'b0);
        chk("t4_q_after", q, 1'b0);

        // 6: third clean press -> Q=1.
        btn = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick(1);
            chk($sformatf("t6_T0_e%0d", n), i0.T, (n == 6));
        end
        chk("t6_q_press3", q, 1'b1);
        btn = 1'b0;
        tick(8);
        chk("t6_lvl0_released", i0.btn_level, 1'b0);

        // 6: reset during PRESS_WAIT abandons the press; Q cleared.
        btn = 1'b1;
        tick(3);
        chk("t6_pw_T0", i0.T, 1'b0);
        reset = 1'b1;
        tick(1);
        chk("t6_rst_T0", i0.T, 1'b0);
        chk("t6_rst_lvl0", i0.btn_level, 1'b0);
        chk("t6_rst_q", q, 1'b0);
        reset = 1'b0;

        // Held through reset: re-debounced from IDLE, one pulse at normal latency.
        for (int n = 1; n <= 10; n++) begin
            tick(1);
            chk($sformatf("t6r_T0_e%0d", n), i0.T, (n == 6));
            chk($sformatf("t6r_lvl0_e%0d", n), i0.btn_level, (n >= 6));
        end
        chk("t6r_q", q, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
